// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures memory-stage results and presents them to writeback one cycle later.
// Priority is reset > flush (bubble) > stall (hold) > capture; wb_data_out is combinational off the flops.
module mem_wb_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [REG_AW-1:0] reg_write_addr_in,
  input  logic              reg_write_en_in,
  input  logic              mem_to_reg_in,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [REG_AW-1:0] reg_write_addr_out,
  output logic              reg_write_en_out,
  output logic              mem_to_reg_out,
  output logic [DATA_W-1:0] wb_data_out
);

  typedef struct packed {
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_AW-1:0] reg_write_addr;
    logic              reg_write_en;
    logic              mem_to_reg;
  } wb_stage_t;

  wb_stage_t wb_d;
  wb_stage_t wb_q;

  always_comb begin
    wb_d = wb_q;
    if (flush) begin
      wb_d = '0;
    end else if (!stall) begin
      wb_d.mem_data       = mem_data_in;
      wb_d.alu_result     = alu_result_in;
      wb_d.reg_write_addr = reg_write_addr_in;
      // x0 is hard-wired to zero, so a write to it is dropped here once
      wb_d.reg_write_en   = reg_write_en_in && (reg_write_addr_in != '0);
      wb_d.mem_to_reg     = mem_to_reg_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign mem_data_out       = wb_q.mem_data;
  assign alu_result_out     = wb_q.alu_result;
  assign reg_write_addr_out = wb_q.reg_write_addr;
  assign reg_write_en_out   = wb_q.reg_write_en;
  assign mem_to_reg_out     = wb_q.mem_to_reg;
  assign wb_data_out        = wb_q.mem_to_reg ? wb_q.mem_data : wb_q.alu_result;

endmodule

// File: tb/tb_mem_wb_reg.sv
// Scoreboard bench for mem_wb_reg: each edge's expected outputs are queued when inputs are driven.
module tb_mem_wb_reg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int OW     = 3 * DATA_W + REG_AW + 2;

  logic              clk;
  logic              reset;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [REG_AW-1:0] reg_write_addr_in;
  logic              reg_write_en_in;
  logic              mem_to_reg_in;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] alu_result_out;
  logic [REG_AW-1:0] reg_write_addr_out;
  logic              reg_write_en_out;
  logic              mem_to_reg_out;
  logic [DATA_W-1:0] wb_data_out;

  mem_wb_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .flush             (flush),
    .mem_data_in       (mem_data_in),
    .alu_result_in     (alu_result_in),
    .reg_write_addr_in (reg_write_addr_in),
    .reg_write_en_in   (reg_write_en_in),
    .mem_to_reg_in     (mem_to_reg_in),
    .mem_data_out      (mem_data_out),
    .alu_result_out    (alu_result_out),
    .reg_write_addr_out(reg_write_addr_out),
    .reg_write_en_out  (reg_write_en_out),
    .mem_to_reg_out    (mem_to_reg_out),
    .wb_data_out       (wb_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: what the outputs should hold after the last edge.
  logic [DATA_W-1:0] m_mem;
  logic [DATA_W-1:0] m_alu;
  logic [REG_AW-1:0] m_addr;
  logic              m_en;
  logic              m_m2r;

  logic [OW-1:0] sb[$];
  logic [OW-1:0] exp_v;
  logic [OW-1:0] obs_v;

  function automatic logic [OW-1:0] pack_exp(logic [DATA_W-1:0] md, logic [DATA_W-1:0] ar,
                                             logic [REG_AW-1:0] ad, logic en, logic m2r);
    return {md, ar, ad, en, m2r, (m2r ? md : ar)};
  endfunction

  function automatic logic [OW-1:0] pack_obs();
    return {mem_data_out, alu_result_out, reg_write_addr_out, reg_write_en_out,
            mem_to_reg_out, wb_data_out};
  endfunction

  // Advance the model for the current inputs, queue the expectation, then cross one edge.
  task automatic step();
    if (reset || flush) begin
      m_mem = '0; m_alu = '0; m_addr = '0; m_en = 1'b0; m_m2r = 1'b0;
    end else if (!stall) begin
      m_mem  = mem_data_in;
      m_alu  = alu_result_in;
      m_addr = reg_write_addr_in;
      m_en   = reg_write_en_in & (reg_write_addr_in != 5'd0);
      m_m2r  = mem_to_reg_in;
    end
    sb.push_back(pack_exp(m_mem, m_alu, m_addr, m_en, m_m2r));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [DATA_W-1:0] md, logic [DATA_W-1:0] ar, logic [REG_AW-1:0] ad,
                       logic en, logic m2r);
    mem_data_in       = md;
    alu_result_in     = ar;
    reg_write_addr_in = ad;
    reg_write_en_in   = en;
    mem_to_reg_in     = m2r;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(32'hDEADBEEF, 32'hCAFEF00D, 5'd17, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      exp_v = sb.pop_front();
      obs_v = pack_obs();
      n_cmp++;
      if (obs_v !== exp_v || obs_v !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h want %h", i, obs_v, exp_v);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_capture();
    drive(32'hA5A5A5A5, 32'h5A5A5A5A, 5'b10101, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (pack_obs() !== '0) begin
      n_fail++;
      $display("FAIL capture_pre_edge: got %h want 0", pack_obs());
    end
    step();
    exp_v = sb.pop_front();
    obs_v = pack_obs();
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL capture_vec1: got %h want %h", obs_v, exp_v);
    end
    n_cmp++;
    if (wb_data_out !== 32'hA5A5A5A5 || reg_write_en_out !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_vec1_wb: wb %h en %b want A5A5A5A5 1", wb_data_out, reg_write_en_out);
    end
    drive(32'hFFFFFFFF, 32'h00000000, 5'b01010, 1'b0, 1'b0);
    step();
    exp_v = sb.pop_front();
    obs_v = pack_obs();
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL capture_vec2: got %h want %h", obs_v, exp_v);
    end
    n_cmp++;
    if (wb_data_out !== 32'h0 || mem_data_out !== 32'hFFFFFFFF || reg_write_addr_out !== 5'b01010) begin
      n_fail++;
      $display("FAIL capture_vec2_fields: wb %h mem %h addr %b", wb_data_out, mem_data_out, reg_write_addr_out);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    drive(32'h11112222, 32'h33334444, 5'd9, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = sb.pop_front();
      obs_v = pack_obs();
      n_cmp++;
      if (obs_v !== exp_v || mem_data_out !== 32'hFFFFFFFF) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, obs_v, exp_v);
      end
    end
    stall = 1'b0;
    step();
    exp_v = sb.pop_front();
    obs_v = pack_obs();
    n_cmp++;
    if (obs_v !== exp_v || wb_data_out !== 32'h11112222) begin
      n_fail++;
      $display("FAIL stall_release: got %h want %h", obs_v, exp_v);
    end
  endtask

  task automatic test_flush();
    stall = 1'b1; flush = 1'b1;
    drive(32'h0BAD0BAD, 32'h76543210, 5'd7, 1'b1, 1'b1);
    step();
    exp_v = sb.pop_front();
    obs_v = pack_obs();
    n_cmp++;
    if (obs_v !== exp_v || obs_v !== '0) begin
      n_fail++;
      $display("FAIL flush_over_stall: got %h want %h", obs_v, exp_v);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reg0();
    drive(32'h9999AAAA, 32'h12345678, 5'd0, 1'b1, 1'b0);
    step();
    exp_v = sb.pop_front();
    obs_v = pack_obs();
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL reg0_write: got %h want %h", obs_v, exp_v);
    end
    n_cmp++;
    if (reg_write_en_out !== 1'b0 || reg_write_addr_out !== 5'd0 || alu_result_out !== 32'h12345678) begin
      n_fail++;
      $display("FAIL reg0_fields: en %b addr %0d alu %h want 0 0 12345678",
               reg_write_en_out, reg_write_addr_out, alu_result_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      reset = (i == 30);
      drive($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
      step();
      exp_v = sb.pop_front();
      obs_v = pack_obs();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] rst%b fl%b st%b: got %h want %h",
                 i, reset, flush, stall, obs_v, exp_v);
      end
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    m_mem = '0; m_alu = '0; m_addr = '0; m_en = 1'b0; m_m2r = 1'b0;
    test_reset();
    test_capture();
    test_stall();
    test_flush();
    test_reg0();
    test_back_to_back();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_reg.md
Name: mem_wb_reg

Overview:
- MEM/WB pipeline register of the 5-stage core.
- Captures the memory-stage results (load data, ALU result, destination register, write enable, writeback select) and presents them to the writeback stage one cycle later.
- Supports stall (hold) and flush (bubble insertion).
- Provides the final muxed writeback data to the register file.

Parameters:
- DATA_W, 32, width of memory-data and ALU-result paths
- REG_AW, 5, register-file address width

Ports:
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all registered outputs this cycle
- flush  in  1  load a bubble this cycle
- mem_data_in  in  DATA_W  data read from data memory
- alu_result_in  in  DATA_W  ALU result / address from MEM stage
- reg_write_addr_in  in  REG_AW  destination register index
- reg_write_en_in  in  1  register write enable
- mem_to_reg_in  in  1  1 = write back memory data, 0 = ALU result
- mem_data_out  out  DATA_W  registered mem_data_in
- alu_result_out  out  DATA_W  registered alu_result_in
- reg_write_addr_out  out  REG_AW  registered destination index
- reg_write_en_out  out  1  registered write enable (qualified, see below)
- mem_to_reg_out  out  1  registered writeback select
- wb_data_out  out  DATA_W  combinational: mem_to_reg_out ? mem_data_out : alu_result_out

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high, sampled on the rising edge of `clk`.
- All state updates on the rising edge of clk. Priority order: reset > flush > stall > capture.
- Reset: every registered output goes to 0 at the first rising edge with reset=1. This includes mem_data_out, alu_result_out, reg_write_addr_out, reg_write_en_out and mem_to_reg_out. wb_data_out therefore also reads 0. Outputs stay 0 for every edge while reset is held.
- Before the first reset, output values are undefined. The bench must not check them.
- Flush (reset=0, flush=1): reg_write_en_out <= 0, reg_write_addr_out <= 0, mem_to_reg_out <= 0, mem_data_out <= 0, alu_result_out <= 0. Flush overrides a simultaneous stall.
- Stall (reset=0, flush=0, stall=1): all registered outputs keep their previous value. Inputs are ignored.
- Capture (reset=0, flush=0, stall=0): every *_out <= corresponding *_in. Latency is exactly one cycle: inputs applied before edge N appear after edge N.
- Write-enable qualification: when captured reg_write_addr_in == 0, reg_write_en_out is stored as 0, because register 0 is hard-wired. The address is still stored.
- Data paths pass through bit-exact, with no arithmetic. wb_data_out is purely combinational from the registered outputs and has no additional latency.
- Inputs changing between edges have no effect on outputs until the next edge.
- Back-to-back captures on consecutive edges must each be reflected independently.

Test Plan:
- Reset: drive arbitrary nonzero inputs, hold reset=1 across one rising edge. All outputs = 0, including wb_data_out = 0x00000000.
- Capture: reset=0, stall=flush=0; mem_data_in=0xA5A5A5A5, alu_result_in=0x5A5A5A5A, reg_write_addr_in=5'b10101, reg_write_en_in=1, mem_to_reg_in=1. After the next edge, outputs equal those values and wb_data_out=0xA5A5A5A5. Before that edge, outputs are still 0.
- Second vector: mem_data_in=0xFFFFFFFF, alu_result_in=0x00000000, addr=5'b01010, en=0, mem_to_reg_in=0. After the next edge, outputs update to those values and wb_data_out=0x00000000.
- Stall: with the previous values latched, set stall=1 and change all inputs. Outputs are unchanged for 3 edges. Releasing stall captures the new inputs on the next edge.
- Flush vs stall: stall=1 and flush=1 together with en=1, addr=7. After the edge, reg_write_en_out=0, addr=0 and both data outputs are 0.
- Register-0 write: addr_in=0, en_in=1, alu_result_in=0x12345678. After the edge, reg_write_en_out=0, reg_write_addr_out=0 and alu_result_out=0x12345678.
